// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile_if
//  Description : Bus bundle between the pipeline and the write-back register
//                file: write-back, issue, read-port and status signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_regfile_if #(
    parameter int CNT_W = 64
);
    logic             wb_e_i;
    logic [4:0]       wb_regd_i;
    logic [31:0]      wb_res_i;
    logic             iss_e_i;
    logic [4:0]       iss_regd_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [31:0]      rd1_o;
    logic [31:0]      rd2_o;
    logic             busy1_o;
    logic             busy2_o;
    logic             stall_o;
    logic [CNT_W-1:0] instret_o;
    logic             err_o;

    modport master (
        output wb_e_i, wb_regd_i, wb_res_i, iss_e_i, iss_regd_i, rs1_i, rs2_i,
        input  rd1_o, rd2_o, busy1_o, busy2_o, stall_o, instret_o, err_o
    );

    modport slave (
        input  wb_e_i, wb_regd_i, wb_res_i, iss_e_i, iss_regd_i, rs1_i, rs2_i,
        output rd1_o, rd2_o, busy1_o, busy2_o, stall_o, instret_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : Write-back stage with 32x32 register file, pending-write
//                scoreboard and retired-instruction counter. Define
//                WB_BYPASS_EN to forward the final write-back to the reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int PEND_W = 2,
    parameter int CNT_W  = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         rdy,
    wb_regfile_if.slave       bus
);
    localparam logic [PEND_W-1:0] c_PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] c_PEND_ONE = PEND_W'(1);

    logic [31:0]       w_reg  [32];
    logic [PEND_W-1:0] w_pend [32];
    logic [31:0]       w_unf;
    logic              w_wb_acc;
    logic              w_iss_acc;
    logic [CNT_W-1:0]  instret_q;
    logic              err_q;

    assign w_wb_acc  = rdy && bus.wb_e_i;
    assign w_iss_acc = rdy && bus.iss_e_i;

    // x0 is a constant: never stored, never pending, never underflows
    assign w_reg[0]  = '0;
    assign w_pend[0] = '0;
    assign w_unf[0]  = 1'b0;

    for (genvar r = 1; r < 32; r++) begin : g_reg
        logic [31:0]       reg_q;
        logic [PEND_W-1:0] pend_q;
        logic [PEND_W-1:0] pend_d;
        logic              w_wb_hit;
        logic              w_iss_hit;

        assign w_wb_hit  = w_wb_acc  && (bus.wb_regd_i  == 5'(r));
        assign w_iss_hit = w_iss_acc && (bus.iss_regd_i == 5'(r));
        assign w_unf[r]  = w_wb_hit && !w_iss_hit && (pend_q == '0);

        always_comb begin
            pend_d = pend_q;
            if (w_iss_hit && !w_wb_hit && (pend_q != c_PEND_MAX))
                pend_d = pend_q + PEND_W'(1);
            else if (w_wb_hit && !w_iss_hit && (pend_q != '0))
                pend_d = pend_q - PEND_W'(1);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                reg_q  <= '0;
                pend_q <= '0;
            end else begin
                if (w_wb_hit)
                    reg_q <= bus.wb_res_i;
                pend_q <= pend_d;
            end
        end

        assign w_reg[r]  = reg_q;
        assign w_pend[r] = pend_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (w_wb_acc)
                instret_q <= instret_q + CNT_W'(1);
            if (|w_unf)
                err_q <= 1'b1;
        end
    end

    logic w_byp1;
    logic w_byp2;

`ifdef WB_BYPASS_EN
    // Forward only the last outstanding write; older in-flight values stay hidden
    assign w_byp1 = w_wb_acc && (bus.rs1_i != 5'd0) && (bus.wb_regd_i == bus.rs1_i)
                    && (w_pend[bus.rs1_i] == c_PEND_ONE);
    assign w_byp2 = w_wb_acc && (bus.rs2_i != 5'd0) && (bus.wb_regd_i == bus.rs2_i)
                    && (w_pend[bus.rs2_i] == c_PEND_ONE);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign bus.rd1_o     = w_byp1 ? bus.wb_res_i : w_reg[bus.rs1_i];
    assign bus.rd2_o     = w_byp2 ? bus.wb_res_i : w_reg[bus.rs2_i];
    assign bus.busy1_o   = !w_byp1 && (w_pend[bus.rs1_i] != '0);
    assign bus.busy2_o   = !w_byp2 && (w_pend[bus.rs2_i] != '0);
    assign bus.stall_o   = (w_pend[bus.iss_regd_i] == c_PEND_MAX);
    assign bus.instret_o = instret_q;
    assign bus.err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_regfile
//  Description : Directed self-checking bench for wb_regfile with an expected-
//                value queue drained at each sample point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;
    localparam int CNT_W = 64;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    localparam int S_RD1 = 0, S_RD2 = 1, S_BUSY1 = 2, S_BUSY2 = 3,
                   S_STALL = 4, S_INSTRET = 5, S_ERR = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    wb_regfile_if #(.CNT_W(CNT_W)) bus ();

    wb_regfile #(.PEND_W(2), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] obs(int sel);
        case (sel)
            S_RD1:     return {32'd0, bus.rd1_o};
            S_RD2:     return {32'd0, bus.rd2_o};
            S_BUSY1:   return {63'd0, bus.busy1_o};
            S_BUSY2:   return {63'd0, bus.busy2_o};
            S_STALL:   return {63'd0, bus.stall_o};
            S_INSTRET: return bus.instret_o;
            default:   return {63'd0, bus.err_o};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(string tag, int sel, logic [63:0] v);
        sb.push_back('{tag: tag, sel: sel, exp: v});
    endtask

    task automatic check();
        exp_t        e;
        logic [63:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            vectors++;
            assert (o === e.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
    endtask

    initial begin
        bus.wb_e_i = 1'b0; bus.wb_regd_i = 5'd0; bus.wb_res_i = 32'd0;
        bus.iss_e_i = 1'b0; bus.iss_regd_i = 5'd0;
        bus.rs1_i = 5'd5; bus.rs2_i = 5'd0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Reset state
        expect_v("rst_rd1", S_RD1, 0);       expect_v("rst_rd2", S_RD2, 0);
        expect_v("rst_busy1", S_BUSY1, 0);   expect_v("rst_busy2", S_BUSY2, 0);
        expect_v("rst_stall", S_STALL, 0);   expect_v("rst_instret", S_INSTRET, 0);
        expect_v("rst_err", S_ERR, 0);
        check();

        // Issue x7, write back six cycles later
        bus.rs1_i = 5'd7; bus.iss_e_i = 1'b1; bus.iss_regd_i = 5'd7;
        expect_v("iss7_busy_pre", S_BUSY1, 0);
        check();
        tick();
        bus.iss_e_i = 1'b0; bus.iss_regd_i = 5'd0;
        for (int i = 0; i < 5; i++) begin
            expect_v("x7_busy_wait", S_BUSY1, 1);
            check();
            tick();
        end
        bus.wb_e_i = 1'b1; bus.wb_regd_i = 5'd7; bus.wb_res_i = 32'hDEADBEEF;
`ifdef WB_BYPASS_EN
        expect_v("x7_wb_rd1", S_RD1, 64'hDEADBEEF);
        expect_v("x7_wb_busy1", S_BUSY1, 0);
`else
        expect_v("x7_wb_rd1", S_RD1, 0);
        expect_v("x7_wb_busy1", S_BUSY1, 1);
`endif
        check();
        tick();
        bus.wb_e_i = 1'b0;
        expect_v("x7_post_rd1", S_RD1, 64'hDEADBEEF);
        expect_v("x7_post_busy1", S_BUSY1, 0);
        expect_v("x7_instret", S_INSTRET, 1);
        expect_v("x7_err", S_ERR, 0);
        check();

        // Write-back to x0
        bus.rs1_i = 5'd0; bus.rs2_i = 5'd0;
        bus.wb_e_i = 1'b1; bus.wb_regd_i = 5'd0; bus.wb_res_i = 32'h12345678;
        tick();
        bus.wb_e_i = 1'b0;
        expect_v("x0_rd1", S_RD1, 0);  expect_v("x0_rd2", S_RD2, 0);
        expect_v("x0_busy1", S_BUSY1, 0);
        expect_v("x0_instret", S_INSTRET, 2);
        expect_v("x0_err", S_ERR, 0);
        check();

        // Saturate x3, then drain it
        bus.iss_regd_i = 5'd3; bus.rs2_i = 5'd3;
        expect_v("x3_stall_pre", S_STALL, 0);
        check();
        bus.iss_e_i = 1'b1;
        repeat (3) tick();
        bus.iss_e_i = 1'b0;
        expect_v("x3_stall_full", S_STALL, 1);
        expect_v("x3_busy2", S_BUSY2, 1);
        check();
        bus.rs1_i = 5'd3;
        bus.wb_e_i = 1'b1; bus.wb_regd_i = 5'd3; bus.wb_res_i = 32'h33;
        tick();
        expect_v("x3_stall_drop", S_STALL, 0);
        expect_v("x3_busy_mid", S_BUSY1, 1);
        check();
        bus.wb_res_i = 32'h34;
        tick();
        bus.wb_res_i = 32'h35;
        tick();
        bus.wb_e_i = 1'b0;
        expect_v("x3_busy1_clr", S_BUSY1, 0);
        expect_v("x3_busy2_clr", S_BUSY2, 0);
        expect_v("x3_rd1", S_RD1, 64'h35);
        expect_v("x3_instret", S_INSTRET, 5);
        expect_v("x3_err", S_ERR, 0);
        check();

        // Underflow on x4
        bus.iss_regd_i = 5'd0; bus.rs1_i = 5'd4;
        bus.wb_e_i = 1'b1; bus.wb_regd_i = 5'd4; bus.wb_res_i = 32'hA5A5A5A5;
        tick();
        bus.wb_e_i = 1'b0;
        expect_v("unf_err", S_ERR, 1);
        expect_v("unf_rd1", S_RD1, 64'hA5A5A5A5);
        expect_v("unf_busy1", S_BUSY1, 0);
        expect_v("unf_instret", S_INSTRET, 6);
        check();
        tick();
        expect_v("unf_err_sticky", S_ERR, 1);
        check();

        // Simultaneous issue and write-back to x9 with one pending
        bus.rs2_i = 5'd9; bus.iss_e_i = 1'b1; bus.iss_regd_i = 5'd9;
        tick();
        bus.wb_e_i = 1'b1; bus.wb_regd_i = 5'd9; bus.wb_res_i = 32'h99;
        tick();
        bus.iss_e_i = 1'b0; bus.wb_e_i = 1'b0;
        expect_v("x9_busy2", S_BUSY2, 1);
        expect_v("x9_rd2", S_RD2, 64'h99);
        expect_v("x9_instret", S_INSTRET, 7);
        check();

        // Freeze with a write-back presented
        rdy = 1'b0;
        bus.wb_e_i = 1'b1; bus.wb_regd_i = 5'd9; bus.wb_res_i = 32'h77;
        expect_v("frz_busy2_now", S_BUSY2, 1);
        expect_v("frz_rd2_now", S_RD2, 64'h99);
        check();
        repeat (2) tick();
        expect_v("frz_rd2", S_RD2, 64'h99);
        expect_v("frz_busy2", S_BUSY2, 1);
        expect_v("frz_instret", S_INSTRET, 7);
        expect_v("frz_err", S_ERR, 1);
        check();
        rdy = 1'b1; bus.wb_e_i = 1'b0;

        // Asynchronous reset between clock edges
        tick();
        #2;
        rst = 1'b0;
        expect_v("arst_instret", S_INSTRET, 0);
        expect_v("arst_err", S_ERR, 0);
        expect_v("arst_busy2", S_BUSY2, 0);
        expect_v("arst_rd2", S_RD2, 0);
        expect_v("arst_rd1", S_RD1, 0);
        check();
        tick();
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
